// File: rtl/riscv_core_mdu_pkg.sv
// Shared types and helpers for the multiply/divide control block.
package riscv_core_mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FAST = 3'd1,
    ST_MUL  = 3'd2,
    ST_DIV  = 3'd3,
    ST_RESP = 3'd4
  } mdu_state_e;

  // Most-negative 32-bit value, used for word-op overflow detection.
  localparam logic [31:0] MOST_NEG_W = 32'h8000_0000;

  // Most-negative value for a given datapath width (truncate to XLEN at use).
  function automatic logic [63:0] mdu_most_neg(input int xlen);
    return (xlen == 32) ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
  endfunction

  function automatic logic op_is_mul(input mdu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

  function automatic logic op_is_rem(input mdu_op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  function automatic logic op_is_signed_div(input mdu_op_e op);
    return op inside {OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/riscv_core_mdu_fast_detect.sv
// Combinational detection of operations resolvable without the iterative units:
// divide by zero, signed overflow, and multiplication by zero.
module riscv_core_mdu_fast_detect
  import riscv_core_mdu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  mdu_op_e          op,
  input  logic [XLEN-1:0]  src_a,
  input  logic [XLEN-1:0]  src_b,
  input  logic             isword,
  output logic             is_fast,
  output logic [XLEN-1:0]  fast_data,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam logic [XLEN-1:0] MOST_NEG = XLEN'(mdu_most_neg(XLEN));

  logic              word;
  logic              a_zero;
  logic              b_zero;
  logic              ovf_case;
  logic signed [31:0] a_lo;
  logic [XLEN-1:0]   dividend;

  assign word = (XLEN == 64) && isword;
  assign a_lo = src_a[31:0];

  // Classify the operation and build the shortcut result.
  always_comb begin
    a_zero      = word ? (src_a[31:0] == 32'd0) : (src_a == '0);
    b_zero      = word ? (src_b[31:0] == 32'd0) : (src_b == '0);
    ovf_case    = op_is_signed_div(op) &&
                  (word ? ((src_a[31:0] == MOST_NEG_W) && (src_b[31:0] == 32'hFFFF_FFFF))
                        : ((src_a == MOST_NEG) && (src_b == {XLEN{1'b1}})));
    // Word results are always sign-extended from bit 31, even for unsigned ops.
    dividend    = word ? XLEN'(a_lo) : src_a;
    is_fast     = 1'b0;
    fast_data   = '0;
    div_by_zero = 1'b0;
    overflow    = 1'b0;
    if (op_is_mul(op)) begin
      is_fast = a_zero || b_zero;
    end else if (b_zero) begin
      is_fast     = 1'b1;
      div_by_zero = 1'b1;
      fast_data   = op_is_rem(op) ? dividend : {XLEN{1'b1}};
    end else if (ovf_case) begin
      is_fast   = 1'b1;
      overflow  = 1'b1;
      fast_data = op_is_rem(op) ? '0 : dividend;
    end
  end

endmodule

// File: rtl/riscv_core_mdu_ctrl.sv
// Multiply/divide sequencing: accepts a request, resolves trivial cases or a
// cached DIV/REM counterpart directly, otherwise drives the iterative units.
module riscv_core_mdu_ctrl
  import riscv_core_mdu_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic             i_mdu_ctrl_clk,
  input  logic             i_mdu_ctrl_rst,
  input  logic             i_mdu_ctrl_req_valid,
  output logic             o_mdu_ctrl_req_ready,
  input  logic [XLEN-1:0]  i_mdu_ctrl_srcA,
  input  logic [XLEN-1:0]  i_mdu_ctrl_srcB,
  input  logic [2:0]       i_mdu_ctrl_control,
  input  logic             i_mdu_ctrl_isword,
  input  logic             i_mdu_ctrl_flush,
  output logic             o_mdu_ctrl_mul_start,
  output logic             o_mdu_ctrl_div_start,
  input  logic             i_mdu_ctrl_mul_dn,
  input  logic             i_mdu_ctrl_div_dn,
  input  logic [XLEN-1:0]  i_mdu_ctrl_mul_res,
  input  logic [XLEN-1:0]  i_mdu_ctrl_div_quot,
  input  logic [XLEN-1:0]  i_mdu_ctrl_div_rem,
  output logic             o_mdu_ctrl_rsp_valid,
  input  logic             i_mdu_ctrl_rsp_ready,
  output logic [XLEN-1:0]  o_mdu_ctrl_rsp_data,
  output logic             o_mdu_ctrl_div_by_zero,
  output logic             o_mdu_ctrl_overflow,
  output logic             o_mdu_ctrl_busy
);

  mdu_state_e      state_reg, state_next;
  mdu_op_e         op_reg, req_op, det_op;
  logic [XLEN-1:0] a_reg, b_reg, det_a, det_b;
  logic            word_reg, req_word, det_word;
  logic            hit_reg, accept, cache_hit;
  logic            fast, fast_dbz, fast_ovf;
  logic [XLEN-1:0] fast_data;
  logic [XLEN-1:0] rsp_data_reg;
  logic            dbz_reg, ovf_reg;
  logic            cache_vld_reg, cache_word_reg, cache_signed_reg, cache_is_rem_reg;
  logic [XLEN-1:0] cache_a_reg, cache_b_reg, cache_quot_reg, cache_rem_reg;
  logic [XLEN-1:0] quot_fix, rem_fix;

  // Word-op results are sign-extended from bit 31.
  function automatic logic [XLEN-1:0] fix_word(input logic [XLEN-1:0] v, input logic w);
    logic signed [31:0] lo;
    lo = v[31:0];
    return w ? XLEN'(lo) : v;
  endfunction

  assign req_op   = mdu_op_e'(i_mdu_ctrl_control);
  assign req_word = (XLEN == 64) && i_mdu_ctrl_isword;

  // In IDLE the detector looks at the incoming request to pick the next state;
  // afterwards it sees the captured operands to build the FAST-state result.
  assign det_op   = (state_reg == ST_IDLE) ? req_op           : op_reg;
  assign det_a    = (state_reg == ST_IDLE) ? i_mdu_ctrl_srcA  : a_reg;
  assign det_b    = (state_reg == ST_IDLE) ? i_mdu_ctrl_srcB  : b_reg;
  assign det_word = (state_reg == ST_IDLE) ? req_word         : word_reg;

  riscv_core_mdu_fast_detect #(.XLEN(XLEN)) u_fast_detect (
    .op          (det_op),
    .src_a       (det_a),
    .src_b       (det_b),
    .isword      (det_word),
    .is_fast     (fast),
    .fast_data   (fast_data),
    .div_by_zero (fast_dbz),
    .overflow    (fast_ovf)
  );

  // A hit is the opposite half (DIV vs REM) of the division that filled the cache.
  assign cache_hit = CACHE_EN && cache_vld_reg && !op_is_mul(req_op) &&
                     (i_mdu_ctrl_srcA == cache_a_reg) && (i_mdu_ctrl_srcB == cache_b_reg) &&
                     (req_word == cache_word_reg) &&
                     (op_is_signed_div(req_op) == cache_signed_reg) &&
                     (op_is_rem(req_op) != cache_is_rem_reg);

  assign quot_fix = fix_word(i_mdu_ctrl_div_quot, word_reg);
  assign rem_fix  = fix_word(i_mdu_ctrl_div_rem, word_reg);

  // State register.
  always_ff @(posedge i_mdu_ctrl_clk) begin
    if (i_mdu_ctrl_rst) state_reg <= ST_IDLE;
    else                state_reg <= state_next;
  end

  // Next-state, acceptance and start pulses; flush overrides everything.
  always_comb begin
    state_next           = state_reg;
    accept               = 1'b0;
    o_mdu_ctrl_mul_start = 1'b0;
    o_mdu_ctrl_div_start = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (i_mdu_ctrl_req_valid && !i_mdu_ctrl_flush && !i_mdu_ctrl_rst) begin
          accept = 1'b1;
          if (fast || cache_hit) begin
            state_next = ST_FAST;
          end else if (op_is_mul(req_op)) begin
            state_next           = ST_MUL;
            o_mdu_ctrl_mul_start = 1'b1;
          end else begin
            state_next           = ST_DIV;
            o_mdu_ctrl_div_start = 1'b1;
          end
        end
      end
      ST_FAST: state_next = ST_RESP;
      ST_MUL:  if (i_mdu_ctrl_mul_dn) state_next = ST_RESP;
      ST_DIV:  if (i_mdu_ctrl_div_dn) state_next = ST_RESP;
      ST_RESP: if (i_mdu_ctrl_rsp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (i_mdu_ctrl_flush) state_next = ST_IDLE;
  end

  // Request capture, result capture and the quotient/remainder cache.
  always_ff @(posedge i_mdu_ctrl_clk) begin
    if (i_mdu_ctrl_rst) begin
      op_reg           <= OP_MUL;
      a_reg            <= '0;
      b_reg            <= '0;
      word_reg         <= 1'b0;
      hit_reg          <= 1'b0;
      rsp_data_reg     <= '0;
      dbz_reg          <= 1'b0;
      ovf_reg          <= 1'b0;
      cache_vld_reg    <= 1'b0;
      cache_word_reg   <= 1'b0;
      cache_signed_reg <= 1'b0;
      cache_is_rem_reg <= 1'b0;
      cache_a_reg      <= '0;
      cache_b_reg      <= '0;
      cache_quot_reg   <= '0;
      cache_rem_reg    <= '0;
    end else begin
      if (accept) begin
        op_reg   <= req_op;
        a_reg    <= i_mdu_ctrl_srcA;
        b_reg    <= i_mdu_ctrl_srcB;
        word_reg <= req_word;
        hit_reg  <= cache_hit && !fast;
      end
      if (i_mdu_ctrl_flush) begin
        cache_vld_reg <= 1'b0;
      end else begin
        case (state_reg)
          ST_FAST: begin
            rsp_data_reg <= hit_reg ? (op_is_rem(op_reg) ? cache_rem_reg : cache_quot_reg)
                                    : fast_data;
            dbz_reg      <= !hit_reg && fast_dbz;
            ovf_reg      <= !hit_reg && fast_ovf;
          end
          ST_MUL: if (i_mdu_ctrl_mul_dn) begin
            rsp_data_reg <= fix_word(i_mdu_ctrl_mul_res, word_reg);
            dbz_reg      <= 1'b0;
            ovf_reg      <= 1'b0;
          end
          ST_DIV: if (i_mdu_ctrl_div_dn) begin
            rsp_data_reg     <= op_is_rem(op_reg) ? rem_fix : quot_fix;
            dbz_reg          <= 1'b0;
            ovf_reg          <= 1'b0;
            cache_vld_reg    <= 1'b1;
            cache_a_reg      <= a_reg;
            cache_b_reg      <= b_reg;
            cache_word_reg   <= word_reg;
            cache_signed_reg <= op_is_signed_div(op_reg);
            cache_is_rem_reg <= op_is_rem(op_reg);
            cache_quot_reg   <= quot_fix;
            cache_rem_reg    <= rem_fix;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_mdu_ctrl_req_ready   = (state_reg == ST_IDLE);
  assign o_mdu_ctrl_busy        = (state_reg != ST_IDLE);
  assign o_mdu_ctrl_rsp_valid   = (state_reg == ST_RESP);
  assign o_mdu_ctrl_rsp_data    = o_mdu_ctrl_rsp_valid ? rsp_data_reg : '0;
  assign o_mdu_ctrl_div_by_zero = o_mdu_ctrl_rsp_valid && dbz_reg;
  assign o_mdu_ctrl_overflow    = o_mdu_ctrl_rsp_valid && ovf_reg;

endmodule

// File: tb/tb_riscv_core_mdu_ctrl.sv
// Scoreboard bench for riscv_core_mdu_ctrl (XLEN=64, cache enabled).
module tb_riscv_core_mdu_ctrl;

  localparam int XLEN = 64;
  localparam logic [2:0] C_MUL = 3'b000, C_MULHU = 3'b011, C_DIV = 3'b100,
                         C_REM = 3'b110, C_REMU = 3'b111;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid, req_ready;
  logic [XLEN-1:0] src_a, src_b;
  logic [2:0]      control;
  logic            isword, flush;
  logic            mul_start, div_start, mul_dn, div_dn;
  logic [XLEN-1:0] mul_res, div_quot, div_rem;
  logic            rsp_valid, rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic            dbz, ovf, busy;

  typedef struct {
    logic [XLEN-1:0] d;
    logic            z;
    logic            o;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int mul_cnt = 0;
  int div_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mul_start) mul_cnt <= mul_cnt + 1;
    if (div_start) div_cnt <= div_cnt + 1;
  end

  riscv_core_mdu_ctrl #(.XLEN(XLEN), .CACHE_EN(1'b1)) dut (
    .i_mdu_ctrl_clk         (clk),
    .i_mdu_ctrl_rst         (rst),
    .i_mdu_ctrl_req_valid   (req_valid),
    .o_mdu_ctrl_req_ready   (req_ready),
    .i_mdu_ctrl_srcA        (src_a),
    .i_mdu_ctrl_srcB        (src_b),
    .i_mdu_ctrl_control     (control),
    .i_mdu_ctrl_isword      (isword),
    .i_mdu_ctrl_flush       (flush),
    .o_mdu_ctrl_mul_start   (mul_start),
    .o_mdu_ctrl_div_start   (div_start),
    .i_mdu_ctrl_mul_dn      (mul_dn),
    .i_mdu_ctrl_div_dn      (div_dn),
    .i_mdu_ctrl_mul_res     (mul_res),
    .i_mdu_ctrl_div_quot    (div_quot),
    .i_mdu_ctrl_div_rem     (div_rem),
    .o_mdu_ctrl_rsp_valid   (rsp_valid),
    .i_mdu_ctrl_rsp_ready   (rsp_ready),
    .o_mdu_ctrl_rsp_data    (rsp_data),
    .o_mdu_ctrl_div_by_zero (dbz),
    .o_mdu_ctrl_overflow    (ovf),
    .o_mdu_ctrl_busy        (busy)
  );

  task automatic chk_eq(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic w);
    req_valid = 1'b1;
    control   = op;
    src_a     = a;
    src_b     = b;
    isword    = w;
  endtask

  // unit: 0 = fast/cache path, 1 = multiplier, 2 = divider.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic w, input int unit, input int lat,
                       input logic [XLEN-1:0] r1, input logic [XLEN-1:0] r2,
                       input logic [XLEN-1:0] exp_d, input logic exp_z, input logic exp_o,
                       input int stall);
    exp_t e, p;
    int cyc, m0, d0;
    m0 = mul_cnt;
    d0 = div_cnt;
    e.d = exp_d; e.z = exp_z; e.o = exp_o;
    chk_eq({tag, "_req_ready"}, req_ready, 1);
    drive_req(op, a, b, w);
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    if (unit != 0) begin
      repeat (lat - 1) @(negedge clk);
      if (unit == 1) begin mul_dn = 1'b1; mul_res = r1; end
      else begin div_dn = 1'b1; div_quot = r1; div_rem = r2; end
      @(negedge clk);
      mul_dn = 1'b0;
      div_dn = 1'b0;
    end
    while (!rsp_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk_eq({tag, "_rsp_valid"}, rsp_valid, 1);
    if (unit == 0) chk_eq({tag, "_latency"}, cyc, 2);
    for (int i = 0; i < stall; i++) begin
      chk_eq({tag, "_stall_valid"}, rsp_valid, 1);
      chk_eq({tag, "_stall_data"}, rsp_data, exp_d);
      chk_eq({tag, "_stall_ready"}, req_ready, 0);
      @(negedge clk);
    end
    if (sb.size() == 0) begin
      chk_eq({tag, "_sb_empty"}, 0, 1);
    end else begin
      p = sb.pop_front();
      chk_eq({tag, "_data"}, rsp_data, p.d);
      chk_eq({tag, "_dbz"}, dbz, p.z);
      chk_eq({tag, "_ovf"}, ovf, p.o);
    end
    $display("op %s data=%h dbz=%0d ovf=%0d", tag, rsp_data, dbz, ovf);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk_eq({tag, "_done_valid"}, rsp_valid, 0);
    chk_eq({tag, "_done_idle"}, req_ready, 1);
    chk_eq({tag, "_mul_starts"}, mul_cnt - m0, (unit == 1) ? 1 : 0);
    chk_eq({tag, "_div_starts"}, div_cnt - d0, (unit == 2) ? 1 : 0);
  endtask

  initial begin
    int m0, d0;
    rst = 1'b1; req_valid = 1'b0; src_a = '0; src_b = '0; control = '0; isword = 1'b0;
    flush = 1'b0; mul_dn = 1'b0; div_dn = 1'b0; mul_res = '0; div_quot = '0; div_rem = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_eq("rst_req_ready", req_ready, 1);
    chk_eq("rst_rsp_valid", rsp_valid, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_data", rsp_data, 0);
    chk_eq("rst_flags", {dbz, ovf}, 0);
    chk_eq("rst_starts", {mul_start, div_start}, 0);
    $display("op reset done");

    do_op("div_by_zero", C_DIV, 7, 0, 0, 0, 0, 0, 0, {XLEN{1'b1}}, 1, 0, 0);
    do_op("div_ovf", C_DIV, 64'h8000_0000_0000_0000, {XLEN{1'b1}}, 0, 0, 0, 0, 0,
          64'h8000_0000_0000_0000, 0, 1, 0);
    do_op("remw_ovf", C_REM, 64'h0000_0000_8000_0000, {XLEN{1'b1}}, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    do_op("div_100_7", C_DIV, 100, 7, 0, 2, 10, 14, 2, 14, 0, 0, 0);
    do_op("rem_hit", C_REM, 100, 7, 0, 0, 0, 0, 0, 2, 0, 0, 0);
    do_op("mulw_stall", C_MUL, 64'h7FFF_FFFF, 2, 1, 1, 4, 64'hFFFF_FFFE, 0,
          64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 5);
    do_op("mul_zero", C_MUL, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_op("mulhu", C_MULHU, 64'h1234, 64'h5678, 0, 1, 3, 64'hDEAD_BEEF_0123_4567, 0,
          64'hDEAD_BEEF_0123_4567, 0, 0, 0);
    do_op("remu_zero", C_REMU, 9, 0, 0, 0, 0, 0, 0, 9, 1, 0, 0);
    do_op("divw_sext", C_DIV, 64'hFFFF_FFFF_FFFF_FFC9, 8, 1, 2, 6, 64'h0000_0000_FFFF_FFF9, 1,
          64'hFFFF_FFFF_FFFF_FFF9, 0, 0, 0);

    // Flush while dividing, coincident with the done pulse.
    do_op("div_refill", C_DIV, 100, 7, 0, 2, 5, 14, 2, 14, 0, 0, 0);
    d0 = div_cnt;
    drive_req(C_DIV, 100, 7, 0);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    flush = 1'b1; div_dn = 1'b1; div_quot = 14; div_rem = 2;
    @(negedge clk);
    flush = 1'b0; div_dn = 1'b0;
    chk_eq("flush_busy", busy, 0);
    chk_eq("flush_rsp_valid", rsp_valid, 0);
    chk_eq("flush_req_ready", req_ready, 1);
    repeat (3) begin
      @(negedge clk);
      chk_eq("flush_no_rsp", rsp_valid, 0);
    end
    chk_eq("flush_div_starts", div_cnt - d0, 1);
    $display("op flush_in_div busy=%0d rsp_valid=%0d", busy, rsp_valid);
    do_op("rem_after_flush", C_REM, 100, 7, 0, 2, 4, 14, 2, 2, 0, 0, 0);

    // Flush alongside a request in IDLE blocks acceptance.
    m0 = mul_cnt;
    drive_req(C_MUL, 3, 4, 0);
    flush = 1'b1;
    chk_eq("idle_flush_start", mul_start, 0);
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    chk_eq("idle_flush_busy", busy, 0);
    chk_eq("idle_flush_starts", mul_cnt - m0, 0);
    $display("op flush_in_idle busy=%0d", busy);

    // Reset mid-operation; the late done pulse must be ignored.
    m0 = mul_cnt;
    drive_req(C_MUL, 3, 4, 0);
    @(negedge clk);
    req_valid = 1'b0;
    chk_eq("rstmid_busy_before", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_eq("rstmid_busy", busy, 0);
    chk_eq("rstmid_req_ready", req_ready, 1);
    mul_dn = 1'b1; mul_res = 12;
    @(negedge clk);
    mul_dn = 1'b0;
    chk_eq("rstmid_stray_done", rsp_valid, 0);
    chk_eq("rstmid_stray_busy", busy, 0);
    @(negedge clk);
    chk_eq("rstmid_no_rsp", rsp_valid, 0);
    chk_eq("rstmid_starts", mul_cnt - m0, 1);
    chk_eq("sb_drained", sb.size(), 0);
    $display("op reset_mid_op busy=%0d rsp_valid=%0d", busy, rsp_valid);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
